caxi4interconnect_gray_ptr_ctrl: RTL and testbench

Parametrised Gray-coded FIFO pointer controller for one side of a clock-domain-crossing FIFO in the AXI4 interconnect converters. It keeps the local binary and Gray pointer and synchronises the opposite domain's Gray pointer through a configurable flop chain. From these it produces a registered full flag (write side) or empty flag (read side) and a fill level. Two instances, one per clock domain, form the control path of an asynchronous FIFO; the RAM is outside this block.

---
 rtl/caxi4interconnect_gray_ptr_ctrl_pkg.sv | 33 +++
 rtl/caxi4interconnect_gray_ptr_ctrl_sync.sv | 31 +++
 rtl/caxi4interconnect_gray_ptr_ctrl.sv | 98 +++++++++
 tb/tb_caxi4interconnect_gray_ptr_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/caxi4interconnect_gray_ptr_ctrl_pkg.sv
// Shared definitions for the Gray-coded CDC FIFO pointer logic: pointer width,
// Gray/binary conversions and the legal synchroniser depth range.
package caxi4interconnect_gray_ptr_ctrl_pkg;

   // Synchroniser depth limits; fewer than two flops is not metastability-safe.
   localparam int SYNC_STAGES_MIN = 2;
   localparam int SYNC_STAGES_MAX = 4;

   // Conversion functions work on a fixed wide word; callers zero-extend on the
   // way in and truncate on the way out, which keeps both directions exact.
   localparam int GRAY_MAX_W = 32;
   typedef logic [GRAY_MAX_W-1:0] gray_word_t;

   // One extra MSB beyond the address distinguishes full from empty.
   function automatic int ptr_width(input int addr_width);
      return addr_width + 1;
   endfunction

   function automatic gray_word_t bin2gray(input gray_word_t bin);
      return bin ^ (bin >> 32'd1);
   endfunction

   // Bit i of the binary value is the XOR of all Gray bits from the MSB down to i.
   function automatic gray_word_t gray2bin(input gray_word_t gray);
      gray_word_t bin;
      bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
      for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/caxi4interconnect_gray_ptr_ctrl_sync.sv
// N-stage flop synchroniser for a Gray-coded bus. Only safe for values that
// change at most one bit per source clock, which Gray pointers guarantee.
module caxi4interconnect_gray_sync #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] stage_q [STAGES];

   // Shift the asynchronous input through the flop chain; all stages clear on reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < STAGES; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= d_i;
         for (int i = 1; i < STAGES; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/caxi4interconnect_gray_ptr_ctrl.sv
// One side of an asynchronous FIFO's control path: local binary/Gray pointer,
// synchronised remote pointer, registered full (write) or empty (read) flag
// and the occupancy seen from this clock domain.
module caxi4interconnect_gray_ptr_ctrl
   import caxi4interconnect_gray_ptr_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH  = 4,
   parameter int SYNC_STAGES = 2,
   parameter int IS_WRITE    = 1
) (
   input  logic                  ACLK,
   input  logic                  ARESETN,
   input  logic                  incr,
   input  logic [ADDR_WIDTH:0]   remotePtrGray,
   output logic                  accept,
   output logic [ADDR_WIDTH:0]   ptrBin,
   output logic [ADDR_WIDTH:0]   ptrGray,
   output logic                  flag,
   output logic [ADDR_WIDTH:0]   level
);

   localparam int PTR_W = ptr_width(ADDR_WIDTH);

   // Out-of-range depths are pulled back into the legal window.
   localparam int SYNC_N = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN :
                           (SYNC_STAGES > SYNC_STAGES_MAX) ? SYNC_STAGES_MAX : SYNC_STAGES;

   localparam bit WR_SIDE = (IS_WRITE != 0);

   // Inverting the two MSBs of a Gray value equals adding half the pointer range:
   // the write side is full when it is exactly one FIFO depth ahead of the reader.
   localparam logic [PTR_W-1:0] FULL_MASK = PTR_W'(2'b11) << (ADDR_WIDTH - 1);

   logic [PTR_W-1:0] bin_q,  bin_d;
   logic [PTR_W-1:0] gray_q, gray_d;
   logic             flag_q, flag_d;
   logic [PTR_W-1:0] rbin_q;
   logic [PTR_W-1:0] sync_gray_s;
   logic [PTR_W-1:0] sync_bin_s;
   logic [PTR_W-1:0] level_s;
   logic             accept_s;

   caxi4interconnect_gray_sync #(
      .WIDTH  (PTR_W),
      .STAGES (SYNC_N)
   ) u_sync (
      .clk_i  (ACLK),
      .rst_ni (ARESETN),
      .d_i    (remotePtrGray),
      .q_o    (sync_gray_s)
   );

   // Next pointer and next flag; the flag compares the post-update local pointer
   // with the current synchronised remote pointer so it never lags a local accept.
   always_comb begin
      accept_s   = incr & ~flag_q;
      bin_d      = bin_q + {{(PTR_W-1){1'b0}}, accept_s};
      gray_d     = PTR_W'(bin2gray(gray_word_t'(bin_d)));
      sync_bin_s = PTR_W'(gray2bin(gray_word_t'(sync_gray_s)));
      if (WR_SIDE) begin
         flag_d = (gray_d == (sync_gray_s ^ FULL_MASK));
      end else begin
         flag_d = (gray_d == sync_gray_s);
      end
   end

   // Pointer, flag and remote-binary registers; the remote binary is registered so
   // that level moves on the same edge as the flag when the remote side advances.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         bin_q  <= '0;
         gray_q <= '0;
         flag_q <= WR_SIDE ? 1'b0 : 1'b1;
         rbin_q <= '0;
      end else begin
         bin_q  <= bin_d;
         gray_q <= gray_d;
         flag_q <= flag_d;
         rbin_q <= sync_bin_s;
      end
   end

   // Occupancy from registered pointers, modulo the pointer range.
   always_comb begin
      if (WR_SIDE) begin
         level_s = bin_q - rbin_q;
      end else begin
         level_s = rbin_q - bin_q;
      end
   end

   assign accept  = accept_s;
   assign ptrBin  = bin_q;
   assign ptrGray = gray_q;
   assign flag    = flag_q;
   assign level   = level_s;

endmodule

// File: tb/tb_caxi4interconnect_gray_ptr_ctrl.sv
// Self-checking bench: three write-side instances (SYNC_STAGES 2,3,4) sharing
// stimulus plus one read-side instance, ADDR_WIDTH = 2.
module tb_caxi4interconnect_gray_ptr_ctrl;

   localparam int AW = 2;
   localparam int PW = AW + 1;
   localparam int NW = 3;
   localparam int RS = 3;

   logic          ACLK    = 1'b0;
   logic          ARESETN = 1'b1;
   logic          incr_w  = 1'b0;
   logic          incr_r  = 1'b0;
   logic [PW-1:0] remote_w = '0;
   logic [PW-1:0] remote_r = '0;

   logic          w_accept  [NW];
   logic [PW-1:0] w_ptrBin  [NW];
   logic [PW-1:0] w_ptrGray [NW];
   logic          w_flag    [NW];
   logic [PW-1:0] w_level   [NW];

   logic          r_accept;
   logic [PW-1:0] r_ptrBin;
   logic [PW-1:0] r_ptrGray;
   logic          r_flag;
   logic [PW-1:0] r_level;

   int n_checks = 0;
   int n_fail   = 0;

   // Reflected binary sequence for 3 bits, written out as a table.
   logic [PW-1:0] gray_tab [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                                   3'b110, 3'b111, 3'b101, 3'b100};

   int rs_w [0:1023];
   int rs_r [0:1023];

   always #5 ACLK = ~ACLK;

   for (genvar g = 0; g < NW; g++) begin : g_wr
      caxi4interconnect_gray_ptr_ctrl #(
         .ADDR_WIDTH (AW), .SYNC_STAGES (g + 2), .IS_WRITE (1)
      ) u_dut (
         .ACLK (ACLK), .ARESETN (ARESETN), .incr (incr_w), .remotePtrGray (remote_w),
         .accept (w_accept[g]), .ptrBin (w_ptrBin[g]), .ptrGray (w_ptrGray[g]),
         .flag (w_flag[g]), .level (w_level[g])
      );
   end

   caxi4interconnect_gray_ptr_ctrl #(
      .ADDR_WIDTH (AW), .SYNC_STAGES (RS), .IS_WRITE (0)
   ) u_rd (
      .ACLK (ACLK), .ARESETN (ARESETN), .incr (incr_r), .remotePtrGray (remote_r),
      .accept (r_accept), .ptrBin (r_ptrBin), .ptrGray (r_ptrGray),
      .flag (r_flag), .level (r_level)
   );

   task automatic clk1();
      @(posedge ACLK);
      #1;
   endtask

   task automatic do_reset();
      ARESETN  = 1'b0;
      incr_w   = 1'b0;
      incr_r   = 1'b0;
      remote_w = '0;
      remote_r = '0;
      repeat (2) @(posedge ACLK);
      #1;
      ARESETN = 1'b1;
   endtask

   task automatic test_reset();
      ARESETN = 1'b0;
      incr_w  = 1'b1;
      incr_r  = 1'b1;
      #1;
      for (int g = 0; g < NW; g++) begin
         n_checks++; if (w_ptrBin[g] !== 3'd0) begin n_fail++; $display("FAIL reset_ptrBin[%0d]: got %0d expected 0", g, w_ptrBin[g]); end
         n_checks++; if (w_ptrGray[g] !== 3'd0) begin n_fail++; $display("FAIL reset_ptrGray[%0d]: got %0d expected 0", g, w_ptrGray[g]); end
         n_checks++; if (w_flag[g] !== 1'b0) begin n_fail++; $display("FAIL reset_wflag[%0d]: got %b expected 0", g, w_flag[g]); end
         n_checks++; if (w_level[g] !== 3'd0) begin n_fail++; $display("FAIL reset_level[%0d]: got %0d expected 0", g, w_level[g]); end
         n_checks++; if (w_accept[g] !== 1'b1) begin n_fail++; $display("FAIL reset_waccept[%0d]: got %b expected 1", g, w_accept[g]); end
      end
      n_checks++; if (r_flag !== 1'b1) begin n_fail++; $display("FAIL reset_rflag: got %b expected 1", r_flag); end
      n_checks++; if (r_accept !== 1'b0) begin n_fail++; $display("FAIL reset_raccept: got %b expected 0", r_accept); end
      clk1();
      for (int g = 0; g < NW; g++) begin
         n_checks++; if (w_ptrBin[g] !== 3'd0) begin n_fail++; $display("FAIL reset_held_ptrBin[%0d]: got %0d expected 0", g, w_ptrBin[g]); end
      end
      do_reset();
   endtask

   task automatic test_write_fill();
      do_reset();
      for (int k = 1; k <= 4; k++) begin
         incr_w = 1'b1;
         #1;
         for (int g = 0; g < NW; g++) begin
            n_checks++; if (w_accept[g] !== 1'b1) begin n_fail++; $display("FAIL fill_accept[%0d] push %0d: got %b expected 1", g, k, w_accept[g]); end
         end
         clk1();
         for (int g = 0; g < NW; g++) begin
            n_checks++; if (w_ptrBin[g] !== PW'(k)) begin n_fail++; $display("FAIL fill_ptrBin[%0d] push %0d: got %0d expected %0d", g, k, w_ptrBin[g], k); end
         end
      end
      for (int g = 0; g < NW; g++) begin
         n_checks++; if (w_ptrGray[g] !== 3'b110) begin n_fail++; $display("FAIL full_ptrGray[%0d]: got %b expected 110", g, w_ptrGray[g]); end
         n_checks++; if (w_flag[g] !== 1'b1) begin n_fail++; $display("FAIL full_flag[%0d]: got %b expected 1", g, w_flag[g]); end
         n_checks++; if (w_level[g] !== 3'd4) begin n_fail++; $display("FAIL full_level[%0d]: got %0d expected 4", g, w_level[g]); end
         n_checks++; if (w_accept[g] !== 1'b0) begin n_fail++; $display("FAIL full_accept[%0d]: got %b expected 0", g, w_accept[g]); end
      end
      clk1();
      incr_w = 1'b0;
      for (int g = 0; g < NW; g++) begin
         n_checks++; if (w_ptrBin[g] !== 3'd4) begin n_fail++; $display("FAIL full_hold_ptrBin[%0d]: got %0d expected 4", g, w_ptrBin[g]); end
         n_checks++; if (w_ptrGray[g] !== 3'b110) begin n_fail++; $display("FAIL full_hold_ptrGray[%0d]: got %b expected 110", g, w_ptrGray[g]); end
      end
   endtask

   // Runs straight after test_write_fill: all write instances are full.
   task automatic test_flag_latency();
      logic          ef;
      logic [PW-1:0] el;
      remote_w = 3'b001;
      for (int e = 1; e <= 6; e++) begin
         clk1();
         for (int g = 0; g < NW; g++) begin
            ef = (e < g + 3);
            el = ef ? 3'd4 : 3'd3;
            n_checks++; if (w_flag[g] !== ef) begin n_fail++; $display("FAIL latency_flag[S=%0d] edge %0d: got %b expected %b", g + 2, e, w_flag[g], ef); end
            n_checks++; if (w_level[g] !== el) begin n_fail++; $display("FAIL latency_level[S=%0d] edge %0d: got %0d expected %0d", g + 2, e, w_level[g], el); end
         end
      end
   endtask

   task automatic test_read_side();
      logic          ef;
      logic [PW-1:0] el;
      do_reset();
      n_checks++; if (r_flag !== 1'b1) begin n_fail++; $display("FAIL rd_reset_flag: got %b expected 1", r_flag); end
      remote_r = 3'b011;
      for (int e = 1; e <= RS + 2; e++) begin
         clk1();
         ef = (e < RS + 1);
         el = ef ? 3'd0 : 3'd2;
         n_checks++; if (r_flag !== ef) begin n_fail++; $display("FAIL rd_latency_flag edge %0d: got %b expected %b", e, r_flag, ef); end
         n_checks++; if (r_level !== el) begin n_fail++; $display("FAIL rd_latency_level edge %0d: got %0d expected %0d", e, r_level, el); end
      end
      incr_r = 1'b1;
      #1;
      n_checks++; if (r_accept !== 1'b1) begin n_fail++; $display("FAIL rd_pop1_accept: got %b expected 1", r_accept); end
      clk1();
      n_checks++; if (r_ptrBin !== 3'd1) begin n_fail++; $display("FAIL rd_pop1_ptrBin: got %0d expected 1", r_ptrBin); end
      n_checks++; if (r_flag !== 1'b0) begin n_fail++; $display("FAIL rd_pop1_flag: got %b expected 0", r_flag); end
      n_checks++; if (r_level !== 3'd1) begin n_fail++; $display("FAIL rd_pop1_level: got %0d expected 1", r_level); end
      clk1();
      n_checks++; if (r_ptrBin !== 3'd2) begin n_fail++; $display("FAIL rd_pop2_ptrBin: got %0d expected 2", r_ptrBin); end
      n_checks++; if (r_flag !== 1'b1) begin n_fail++; $display("FAIL rd_pop2_flag: got %b expected 1", r_flag); end
      n_checks++; if (r_accept !== 1'b0) begin n_fail++; $display("FAIL rd_empty_accept: got %b expected 0", r_accept); end
      clk1();
      incr_r = 1'b0;
      n_checks++; if (r_ptrBin !== 3'd2) begin n_fail++; $display("FAIL rd_empty_hold_ptrBin: got %0d expected 2", r_ptrBin); end
   endtask

   task automatic test_wrap();
      logic [PW-1:0] prev_w [NW];
      logic [PW-1:0] prev_r;
      do_reset();
      for (int g = 0; g < NW; g++) prev_w[g] = '0;
      prev_r = '0;
      for (int k = 1; k <= 8; k++) begin
         remote_r = gray_tab[k % 8];
         incr_w   = 1'b1;
         clk1();
         incr_w   = 1'b0;
         for (int g = 0; g < NW; g++) begin
            n_checks++; if (w_ptrBin[g] !== PW'(k % 8)) begin n_fail++; $display("FAIL wrap_ptrBin[%0d] op %0d: got %0d expected %0d", g, k, w_ptrBin[g], k % 8); end
            n_checks++; if (w_ptrGray[g] !== gray_tab[k % 8]) begin n_fail++; $display("FAIL wrap_ptrGray[%0d] op %0d: got %b expected %b", g, k, w_ptrGray[g], gray_tab[k % 8]); end
            n_checks++; if (w_flag[g] !== 1'b0) begin n_fail++; $display("FAIL wrap_flag[%0d] op %0d: got %b expected 0", g, k, w_flag[g]); end
            n_checks++; if ($countones(w_ptrGray[g] ^ prev_w[g]) != 1) begin n_fail++; $display("FAIL wrap_gray_onebit[%0d] op %0d: got %b after %b expected one bit change", g, k, w_ptrGray[g], prev_w[g]); end
            prev_w[g] = w_ptrGray[g];
         end
         remote_w = gray_tab[k % 8];
         repeat (5) clk1();
         incr_r = 1'b1;
         #1;
         n_checks++; if (r_accept !== 1'b1) begin n_fail++; $display("FAIL wrap_rd_accept op %0d: got %b expected 1", k, r_accept); end
         clk1();
         incr_r = 1'b0;
         n_checks++; if (r_ptrBin !== PW'(k % 8)) begin n_fail++; $display("FAIL wrap_rd_ptrBin op %0d: got %0d expected %0d", k, r_ptrBin, k % 8); end
         n_checks++; if (r_ptrGray !== gray_tab[k % 8]) begin n_fail++; $display("FAIL wrap_rd_ptrGray op %0d: got %b expected %b", k, r_ptrGray, gray_tab[k % 8]); end
         n_checks++; if (r_flag !== 1'b1) begin n_fail++; $display("FAIL wrap_rd_flag op %0d: got %b expected 1", k, r_flag); end
         n_checks++; if ($countones(r_ptrGray ^ prev_r) != 1) begin n_fail++; $display("FAIL wrap_rd_onebit op %0d: got %b after %b expected one bit change", k, r_ptrGray, prev_r); end
         prev_r = r_ptrGray;
      end
   endtask

   // Instance 0 (two sync stages) pushes on the very edge its remote view advances.
   task automatic test_simultaneous();
      do_reset();
      incr_w = 1'b1;
      repeat (3) clk1();
      incr_w = 1'b0;
      n_checks++; if (w_level[0] !== 3'd3) begin n_fail++; $display("FAIL simul_pre_level: got %0d expected 3", w_level[0]); end
      remote_w = 3'b001;
      for (int e = 1; e <= 2; e++) begin
         clk1();
         n_checks++; if (w_level[0] !== 3'd3) begin n_fail++; $display("FAIL simul_wait_level edge %0d: got %0d expected 3", e, w_level[0]); end
         n_checks++; if (w_flag[0] !== 1'b0) begin n_fail++; $display("FAIL simul_wait_flag edge %0d: got %b expected 0", e, w_flag[0]); end
      end
      incr_w = 1'b1;
      #1;
      n_checks++; if (w_accept[0] !== 1'b1) begin n_fail++; $display("FAIL simul_accept: got %b expected 1", w_accept[0]); end
      clk1();
      incr_w = 1'b0;
      n_checks++; if (w_ptrBin[0] !== 3'd4) begin n_fail++; $display("FAIL simul_ptrBin: got %0d expected 4", w_ptrBin[0]); end
      n_checks++; if (w_flag[0] !== 1'b0) begin n_fail++; $display("FAIL simul_flag: got %b expected 0", w_flag[0]); end
      n_checks++; if (w_level[0] !== 3'd3) begin n_fail++; $display("FAIL simul_level: got %0d expected 3", w_level[0]); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      incr_w = 1'b1;
      repeat (2) clk1();
      incr_w = 1'b0;
      for (int g = 0; g < NW; g++) begin
         n_checks++; if (w_level[g] !== 3'd2) begin n_fail++; $display("FAIL midrst_pre_level[%0d]: got %0d expected 2", g, w_level[g]); end
      end
      #3;
      ARESETN = 1'b0;
      #1;
      for (int g = 0; g < NW; g++) begin
         n_checks++; if (w_ptrBin[g] !== 3'd0) begin n_fail++; $display("FAIL midrst_ptrBin[%0d]: got %0d expected 0", g, w_ptrBin[g]); end
         n_checks++; if (w_ptrGray[g] !== 3'd0) begin n_fail++; $display("FAIL midrst_ptrGray[%0d]: got %b expected 000", g, w_ptrGray[g]); end
         n_checks++; if (w_level[g] !== 3'd0) begin n_fail++; $display("FAIL midrst_level[%0d]: got %0d expected 0", g, w_level[g]); end
         n_checks++; if (w_flag[g] !== 1'b0) begin n_fail++; $display("FAIL midrst_flag[%0d]: got %b expected 0", g, w_flag[g]); end
      end
      n_checks++; if (r_flag !== 1'b1) begin n_fail++; $display("FAIL midrst_rflag: got %b expected 1", r_flag); end
      @(negedge ACLK);
      ARESETN = 1'b1;
      incr_w  = 1'b1;
      #1;
      for (int g = 0; g < NW; g++) begin
         n_checks++; if (w_accept[g] !== 1'b1) begin n_fail++; $display("FAIL midrst_first_accept[%0d]: got %b expected 1", g, w_accept[g]); end
      end
      clk1();
      incr_w = 1'b0;
      for (int g = 0; g < NW; g++) begin
         n_checks++; if (w_ptrBin[g] !== 3'd1) begin n_fail++; $display("FAIL midrst_first_ptrBin[%0d]: got %0d expected 1", g, w_ptrBin[g]); end
      end
   endtask

   // Random pushes/pops and remote-pointer movement checked against an occupancy
   // model: each side sees the remote pointer value that was presented S edges ago.
   task automatic test_random();
      int   cnt_w [NW];
      logic mflag_w [NW];
      int   mlev_w [NW];
      int   cnt_r, mlev_r, rb, wb, edge_n, min_cnt, eff, s;
      logic mflag_r, exp_acc;
      do_reset();
      for (int g = 0; g < NW; g++) begin
         cnt_w[g] = 0; mflag_w[g] = 1'b0; mlev_w[g] = 0;
      end
      cnt_r = 0; mflag_r = 1'b1; mlev_r = 0; rb = 0; wb = 0; edge_n = 0;
      for (int it = 0; it < 400; it++) begin
         incr_w = 1'($urandom_range(0, 1));
         incr_r = 1'($urandom_range(0, 1));
         min_cnt = cnt_w[0];
         for (int g = 1; g < NW; g++) if (cnt_w[g] < min_cnt) min_cnt = cnt_w[g];
         if (rb < min_cnt && $urandom_range(0, 1) == 1) rb++;
         if (wb - cnt_r < 4 && $urandom_range(0, 2) != 0) wb++;
         remote_w = gray_tab[rb % 8];
         remote_r = gray_tab[wb % 8];
         #1;
         for (int g = 0; g < NW; g++) begin
            exp_acc = incr_w & ~mflag_w[g];
            n_checks++; if (w_accept[g] !== exp_acc) begin n_fail++; $display("FAIL rnd_waccept[%0d] it %0d: got %b expected %b", g, it, w_accept[g], exp_acc); end
            if (exp_acc) cnt_w[g]++;
         end
         exp_acc = incr_r & ~mflag_r;
         n_checks++; if (r_accept !== exp_acc) begin n_fail++; $display("FAIL rnd_raccept it %0d: got %b expected %b", it, r_accept, exp_acc); end
         if (exp_acc) cnt_r++;
         @(posedge ACLK);
         edge_n++;
         rs_w[edge_n] = rb;
         rs_r[edge_n] = wb;
         #1;
         for (int g = 0; g < NW; g++) begin
            s   = g + 2;
            eff = (edge_n - s >= 1) ? rs_w[edge_n - s] : 0;
            mlev_w[g]  = (cnt_w[g] - eff) & 7;
            mflag_w[g] = (mlev_w[g] == 4);
            n_checks++; if (w_ptrBin[g] !== PW'(cnt_w[g] % 8)) begin n_fail++; $display("FAIL rnd_wptrBin[%0d] it %0d: got %0d expected %0d", g, it, w_ptrBin[g], cnt_w[g] % 8); end
            n_checks++; if (w_ptrGray[g] !== gray_tab[cnt_w[g] % 8]) begin n_fail++; $display("FAIL rnd_wptrGray[%0d] it %0d: got %b expected %b", g, it, w_ptrGray[g], gray_tab[cnt_w[g] % 8]); end
            n_checks++; if (w_flag[g] !== mflag_w[g]) begin n_fail++; $display("FAIL rnd_wflag[%0d] it %0d: got %b expected %b", g, it, w_flag[g], mflag_w[g]); end
            n_checks++; if (w_level[g] !== PW'(mlev_w[g])) begin n_fail++; $display("FAIL rnd_wlevel[%0d] it %0d: got %0d expected %0d", g, it, w_level[g], mlev_w[g]); end
         end
         eff     = (edge_n - RS >= 1) ? rs_r[edge_n - RS] : 0;
         mlev_r  = (eff - cnt_r) & 7;
         mflag_r = (mlev_r == 0);
         n_checks++; if (r_ptrBin !== PW'(cnt_r % 8)) begin n_fail++; $display("FAIL rnd_rptrBin it %0d: got %0d expected %0d", it, r_ptrBin, cnt_r % 8); end
         n_checks++; if (r_ptrGray !== gray_tab[cnt_r % 8]) begin n_fail++; $display("FAIL rnd_rptrGray it %0d: got %b expected %b", it, r_ptrGray, gray_tab[cnt_r % 8]); end
         n_checks++; if (r_flag !== mflag_r) begin n_fail++; $display("FAIL rnd_rflag it %0d: got %b expected %b", it, r_flag, mflag_r); end
         n_checks++; if (r_level !== PW'(mlev_r)) begin n_fail++; $display("FAIL rnd_rlevel it %0d: got %0d expected %0d", it, r_level, mlev_r); end
      end
      incr_w = 1'b0;
      incr_r = 1'b0;
   endtask

   initial begin
      test_reset();
      test_write_fill();
      test_flag_latency();
      test_read_side();
      test_wrap();
      test_simultaneous();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1);
   end

endmodule
